serial_rx_framed: RTL and testbench
===================================

// Module: serial_rx_framed
// PURPOSE
//   Receiving end of the board's 8N1 serial link driven by the Transmit block.
//   Samples serialInput with a mid-bit strobe, validates the start and stop bits,
//   and presents each byte to the CPU parallel-input PIO with a charReceived/charAck handshake.
//   Reports framing errors and overruns.
// PARAMETERS
//   DATA_BITS    8   data bits per frame, LSB first
//   CLKS_PER_BIT 16  clock cycles per bit period; must be even and >= 4
//   SYNC_STAGES  2   flops in the serialInput synchroniser
// PORTS
//   clock         in   1          single clock (Transmit's bit clock x CLKS_PER_BIT)
//   reset         in   1          asynchronous, active-low
//   serialInput   in   1          line; idle high, start=0, data, stop=1
//   charAck       in   1          CPU pulse: byte consumed, clear status
//   parallelIn    out  DATA_BITS  last good byte
//   charReceived  out  1          byte valid, held until charAck
//   framingError  out  1          sticky: stop bit sampled low
//   overrun       out  1          sticky: byte completed while charReceived=1
// BEHAVIOUR
//   Reset (reset=0, async):
//   - State IDLE; counters 0; sync chain preset to 1.
//   - parallelIn=0, charReceived=0, framingError=0, overrun=0.
//   Sampling: rx = serialInput after SYNC_STAGES flops. N=CLKS_PER_BIT, H=N/2.
//   Edge 0 = the edge on which IDLE sees rx=0.
//   FSM:
//   - IDLE: rx=0 -> START, counter cleared.
//   - START: sample on edge H. rx=1 -> IDLE (glitch, no status change); rx=0 -> DATA.
//   - DATA: bit i sampled on edge H+(i+1)*N. Shift register shifts right,
//     new bit enters at MSB. After bit DATA_BITS-1 -> STOP.
//   - STOP: sample on edge H+(DATA_BITS+1)*N.
//     rx=1 -> complete (see below), -> IDLE.
//     rx=0 -> framingError=1, parallelIn unchanged, charReceived unchanged -> BREAK.
//   - BREAK: wait for rx=1, then -> IDLE. A held-low line yields a single framing error.
//   Completion (registered, visible one edge after the stop sample):
//   - charReceived=0 or charAck=1 that cycle: parallelIn<=shift, charReceived<=1.
//   - charReceived=1 and charAck=0: byte dropped, parallelIn kept, overrun<=1.
//   charAck:
//   - Clears charReceived, framingError and overrun on the next edge.
//   - Ack coincident with completion: new byte loaded, charReceived stays 1, overrun stays 0,
//     framingError cleared.
//   - Ack when nothing is pending: no effect.
//   Latency (defaults): stop sample on edge 152; charReceived high after edge 153.
//   Counters: bit-period counter 0..N-1 wraps; bit index counter 0..DATA_BITS-1; no other arithmetic.
//   Reset mid-frame aborts the frame, discards partial data and returns all outputs to reset values.
// TESTING
//   1. Frame 0xA5 (line 0,1,0,1,0,0,1,0,1,1 per bit) -> parallelIn=0xA5, charReceived=1
//      after edge 153; ack -> 0.
//   2. 3-cycle low glitch on an idle line -> START aborts; no outputs change; next 0x3C
//      frame received correctly.
//   3. 0x5A with stop bit=0 -> framingError=1, parallelIn keeps prior value, charReceived=0;
//      line held low 40 cycles -> still one error.
//   4. 0x11 then 0x22 with no ack -> parallelIn=0x11, overrun=1; ack -> all status 0.
//   5. Ack asserted on the completion edge of 0x77 while 0x66 pending -> parallelIn=0x77,
//      charReceived=1, overrun=0.
//   6. reset low during data bit 4, line released high, then 0xC3 -> outputs 0 during reset;
//      0xC3 received cleanly afterward.

Source files
------------

// File: rtl/serial_rx_framed_if.sv
// rtl/serial_rx_framed_if.sv - line, CPU handshake and status signals of the framed serial receiver
interface serial_rx_framed_if #(
    parameter int DATA_BITS = 8
);
    logic                 serialInput;
    logic                 charAck;
    logic [DATA_BITS-1:0] parallelIn;
    logic                 charReceived;
    logic                 framingError;
    logic                 overrun;

    modport master (
        output serialInput, charAck,
        input  parallelIn, charReceived, framingError, overrun
    );

    modport slave (
        input  serialInput, charAck,
        output parallelIn, charReceived, framingError, overrun
    );
endinterface

// File: rtl/serial_rx_framed.sv
// rtl/serial_rx_framed.sv - 8N1 serial receiver with mid-bit sampling and charReceived/charAck handshake
module serial_rx_framed #(
    parameter int DATA_BITS    = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int SYNC_STAGES  = 2
) (
    input  logic                clock,
    input  logic                reset,
    serial_rx_framed_if.slave   bus
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int IW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] HALF_M1  = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [IW-1:0] IDX_ONE  = IW'(1);
    localparam logic [IW-1:0] IDX_LAST = IW'(DATA_BITS - 1);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_BREAK} state_t;

    state_t               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [IW-1:0]        idx_q, idx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                 done_q, done_d;
    logic                 ferr_set;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 rdy_q, rdy_d;
    logic                 ferr_q, ferr_d;
    logic                 ovr_q, ovr_d;
    logic                 rx;

    generate
        if (SYNC_STAGES == 1) begin : g_sync1
            assign sync_d = bus.serialInput;
        end else begin : g_syncn
            assign sync_d = {sync_q[SYNC_STAGES-2:0], bus.serialInput};
        end
    endgenerate

    assign rx = sync_q[SYNC_STAGES-1];

    // Counter restarts at every sample point so each phase counts from zero.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        shift_d  = shift_q;
        done_d   = 1'b0;
        ferr_set = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!rx) begin
                    state_d = S_START;
                    cnt_d   = '0;
                end
            end
            S_START: begin
                if (cnt_q == HALF_M1) begin
                    cnt_d   = '0;
                    idx_d   = '0;
                    state_d = rx ? S_IDLE : S_DATA;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            S_DATA: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    shift_d = {rx, shift_q[DATA_BITS-1:1]};
                    if (idx_q == IDX_LAST) begin
                        state_d = S_STOP;
                    end else begin
                        idx_d = idx_q + IDX_ONE;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            S_STOP: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d = '0;
                    if (rx) begin
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        ferr_set = 1'b1;
                        state_d  = S_BREAK;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            S_BREAK: begin
                if (rx) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Ack clears first so a coincident completion or framing error still lands.
    always_comb begin
        data_d = data_q;
        rdy_d  = rdy_q;
        ferr_d = ferr_q;
        ovr_d  = ovr_q;
        if (bus.charAck) begin
            rdy_d  = 1'b0;
            ferr_d = 1'b0;
            ovr_d  = 1'b0;
        end
        if (done_q) begin
            if (!rdy_q || bus.charAck) begin
                data_d = shift_q;
                rdy_d  = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end
        if (ferr_set) begin
            ferr_d = 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            sync_q  <= '1;
            done_q  <= 1'b0;
            data_q  <= '0;
            rdy_q   <= 1'b0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            sync_q  <= sync_d;
            done_q  <= done_d;
            data_q  <= data_d;
            rdy_q   <= rdy_d;
            ferr_q  <= ferr_d;
            ovr_q   <= ovr_d;
        end
    end

    assign bus.parallelIn   = data_q;
    assign bus.charReceived = rdy_q;
    assign bus.framingError = ferr_q;
    assign bus.overrun      = ovr_q;
endmodule

// File: tb/tb_serial_rx_framed.sv
// tb/tb_serial_rx_framed.sv - directed self-checking bench for serial_rx_framed
module tb_serial_rx_framed;
    localparam int N = 16;

    logic clock = 1'b0;
    logic reset = 1'b0;
    int   checks = 0;
    int   errors = 0;
    logic [10:0] got;
    logic r155, r156;

    serial_rx_framed_if #(.DATA_BITS(8)) bus ();

    serial_rx_framed #(.DATA_BITS(8), .CLKS_PER_BIT(N), .SYNC_STAGES(2)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    // Bits are driven just after a falling edge; j counts rising edges since the start bit was driven.
    task automatic send_frame(input logic [7:0] data, input logic stop_bit, input int ack_at,
                              output logic rdy155, output logic rdy156);
        logic [9:0] bits;
        int j;
        bits   = {stop_bit, data, 1'b0};
        rdy155 = 1'b0;
        rdy156 = 1'b0;
        for (int b = 0; b < 10; b++) begin
            bus.serialInput = bits[b];
            for (int c = 0; c < N; c++) begin
                @(negedge clock);
                j = b * N + c + 1;
                if (j == 155) rdy155 = bus.charReceived;
                if (j == 156) rdy156 = bus.charReceived;
                if (ack_at > 0) bus.charAck = (j == ack_at);
            end
        end
        bus.charAck = 1'b0;
    endtask

    task automatic pulse_ack();
        bus.charAck = 1'b1;
        @(negedge clock);
        bus.charAck = 1'b0;
        @(negedge clock);
    endtask

    task automatic test_reset();
        bus.serialInput = 1'b1;
        bus.charAck     = 1'b0;
        repeat (3) @(negedge clock);
        got = {bus.charReceived, bus.framingError, bus.overrun, bus.parallelIn};
        checks++;
        if (got !== 11'h000) begin
            errors++;
            $display("FAIL reset_state got %h want %h", got, 11'h000);
        end
        reset = 1'b1;
        repeat (3) @(negedge clock);
    endtask

    task automatic test_basic();
        send_frame(8'hA5, 1'b1, 0, r155, r156);
        checks++;
        if (r155 !== 1'b0) begin
            errors++;
            $display("FAIL latency_early got %b want %b", r155, 1'b0);
        end
        checks++;
        if (r156 !== 1'b1) begin
            errors++;
            $display("FAIL latency_edge153 got %b want %b", r156, 1'b1);
        end
        got = {bus.charReceived, bus.framingError, bus.overrun, bus.parallelIn};
        checks++;
        if (got !== {3'b100, 8'hA5}) begin
            errors++;
            $display("FAIL basic_a5 got %h want %h", got, {3'b100, 8'hA5});
        end
        pulse_ack();
        got = {bus.charReceived, bus.framingError, bus.overrun, bus.parallelIn};
        checks++;
        if (got !== {3'b000, 8'hA5}) begin
            errors++;
            $display("FAIL basic_ack got %h want %h", got, {3'b000, 8'hA5});
        end
    endtask

    task automatic test_glitch();
        bus.serialInput = 1'b0;
        repeat (3) @(negedge clock);
        bus.serialInput = 1'b1;
        repeat (20) @(negedge clock);
        got = {bus.charReceived, bus.framingError, bus.overrun, bus.parallelIn};
        checks++;
        if (got !== {3'b000, 8'hA5}) begin
            errors++;
            $display("FAIL glitch_nochange got %h want %h", got, {3'b000, 8'hA5});
        end
        send_frame(8'h3C, 1'b1, 0, r155, r156);
        got = {bus.charReceived, bus.framingError, bus.overrun, bus.parallelIn};
        checks++;
        if (got !== {3'b100, 8'h3C}) begin
            errors++;
            $display("FAIL glitch_then_3c got %h want %h", got, {3'b100, 8'h3C});
        end
        pulse_ack();
        repeat (4) @(negedge clock);
    endtask

    task automatic test_framing();
        send_frame(8'h5A, 1'b0, 0, r155, r156);
        repeat (8) @(negedge clock);
        got = {bus.charReceived, bus.framingError, bus.overrun, bus.parallelIn};
        checks++;
        if (got !== {3'b010, 8'h3C}) begin
            errors++;
            $display("FAIL framing_set got %h want %h", got, {3'b010, 8'h3C});
        end
        bus.charAck = 1'b1;
        @(negedge clock);
        bus.charAck = 1'b0;
        repeat (30) @(negedge clock);
        got = {bus.charReceived, bus.framingError, bus.overrun, bus.parallelIn};
        checks++;
        if (got !== {3'b000, 8'h3C}) begin
            errors++;
            $display("FAIL framing_single got %h want %h", got, {3'b000, 8'h3C});
        end
        bus.serialInput = 1'b1;
        repeat (20) @(negedge clock);
        got = {bus.charReceived, bus.framingError, bus.overrun, bus.parallelIn};
        checks++;
        if (got !== {3'b000, 8'h3C}) begin
            errors++;
            $display("FAIL framing_release got %h want %h", got, {3'b000, 8'h3C});
        end
    endtask

    task automatic test_overrun();
        send_frame(8'h11, 1'b1, 0, r155, r156);
        got = {bus.charReceived, bus.framingError, bus.overrun, bus.parallelIn};
        checks++;
        if (got !== {3'b100, 8'h11}) begin
            errors++;
            $display("FAIL overrun_first got %h want %h", got, {3'b100, 8'h11});
        end
        repeat (2) @(negedge clock);
        send_frame(8'h22, 1'b1, 0, r155, r156);
        got = {bus.charReceived, bus.framingError, bus.overrun, bus.parallelIn};
        checks++;
        if (got !== {3'b101, 8'h11}) begin
            errors++;
            $display("FAIL overrun_set got %h want %h", got, {3'b101, 8'h11});
        end
        pulse_ack();
        got = {bus.charReceived, bus.framingError, bus.overrun, bus.parallelIn};
        checks++;
        if (got !== {3'b000, 8'h11}) begin
            errors++;
            $display("FAIL overrun_ack got %h want %h", got, {3'b000, 8'h11});
        end
        repeat (2) @(negedge clock);
    endtask

    task automatic test_back_to_back_ack();
        send_frame(8'h66, 1'b1, 0, r155, r156);
        got = {bus.charReceived, bus.framingError, bus.overrun, bus.parallelIn};
        checks++;
        if (got !== {3'b100, 8'h66}) begin
            errors++;
            $display("FAIL pending_66 got %h want %h", got, {3'b100, 8'h66});
        end
        repeat (2) @(negedge clock);
        send_frame(8'h77, 1'b1, 155, r155, r156);
        got = {bus.charReceived, bus.framingError, bus.overrun, bus.parallelIn};
        checks++;
        if (got !== {3'b100, 8'h77}) begin
            errors++;
            $display("FAIL coincident_ack got %h want %h", got, {3'b100, 8'h77});
        end
        repeat (2) @(negedge clock);
    endtask

    task automatic test_reset_midframe();
        logic [9:0] bits;
        bits = {1'b1, 8'hC3, 1'b0};
        for (int b = 0; b < 6; b++) begin
            bus.serialInput = bits[b];
            repeat ((b == 5) ? N / 2 : N) @(negedge clock);
        end
        reset = 1'b0;
        #1;
        got = {bus.charReceived, bus.framingError, bus.overrun, bus.parallelIn};
        checks++;
        if (got !== 11'h000) begin
            errors++;
            $display("FAIL midframe_reset got %h want %h", got, 11'h000);
        end
        repeat (5) @(negedge clock);
        bus.serialInput = 1'b1;
        repeat (3) @(negedge clock);
        reset = 1'b1;
        repeat (5) @(negedge clock);
        got = {bus.charReceived, bus.framingError, bus.overrun, bus.parallelIn};
        checks++;
        if (got !== 11'h000) begin
            errors++;
            $display("FAIL after_reset_idle got %h want %h", got, 11'h000);
        end
        send_frame(8'hC3, 1'b1, 0, r155, r156);
        got = {bus.charReceived, bus.framingError, bus.overrun, bus.parallelIn};
        checks++;
        if (got !== {3'b100, 8'hC3}) begin
            errors++;
            $display("FAIL after_reset_c3 got %h want %h", got, {3'b100, 8'hC3});
        end
    endtask

    initial begin
        bus.serialInput = 1'b1;
        bus.charAck     = 1'b0;
        test_reset();
        test_basic();
        test_glitch();
        test_framing();
        test_overrun();
        test_back_to_back_ack();
        test_reset_midframe();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
